// File: rtl/max_pool_reducer_pkg.sv
// Package: max_pool_reducer_pkg
// Shared definitions for the streaming max-pool stage.
//   pool_state_t : window FSM encodings (IDLE = no partial window, ACCUM = partial)
//   DEF_MAX_POOL : default largest supported window length
//   cnt_width()  : width of pool_size / window counter for a given MAX_POOL
package max_pool_reducer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } pool_state_t;

    localparam int DEF_MAX_POOL = 16;

    // One extra bit so the counter can hold MAX_POOL itself.
    function automatic int cnt_width(input int max_pool);
        return $clog2(max_pool) + 1;
    endfunction

endpackage

// File: rtl/max_pool_reducer_cmp.sv
// Module: signed_max_comparator
// Combinational signed maximum of two operands.
//   a, b    in  IN_WIDTH   signed operands
//   max_val out OUT_WIDTH  signed max(a, b), sign-extended to OUT_WIDTH
// Ties return a (numerically identical to b).
module signed_max_comparator #(
    parameter int IN_WIDTH  = 8,
    parameter int OUT_WIDTH = 8
) (
    input  logic signed [IN_WIDTH-1:0]  a,
    input  logic signed [IN_WIDTH-1:0]  b,
    output logic signed [OUT_WIDTH-1:0] max_val
);

    logic signed [IN_WIDTH-1:0] sel;

    // Pure signed compare: no subtraction, so the most-negative value cannot overflow.
    assign sel     = (a >= b) ? a : b;
    assign max_val = OUT_WIDTH'(sel);

endmodule

// File: rtl/max_pool_reducer.sv
// Module: max_pool_reducer
// Streaming max-pool: reduces each window of pool_size consecutive signed samples
// (or fewer, if in_last closes it early) to its maximum and emits one result.
// Ports:
//   clk, resetn           clock, asynchronous active-low reset
//   pool_size [CNT_WIDTH] window length, sampled on the first sample of a window
//   in_data/in_last/in_valid/in_ready   input stream (valid/ready)
//   out_data/out_valid/out_ready        result stream (valid/ready)
//   busy                  a window is partially accumulated
// Config macro: RELU_POOL_EN -- when defined, results are clamped to >= 0 (fused ReLU).
module max_pool_reducer #(
    parameter int IN_WIDTH  = 8,
    parameter int OUT_WIDTH = 8,
    parameter int MAX_POOL  = max_pool_reducer_pkg::DEF_MAX_POOL,
    parameter int CNT_WIDTH = max_pool_reducer_pkg::cnt_width(MAX_POOL)
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [CNT_WIDTH-1:0] pool_size,
    input  logic [IN_WIDTH-1:0]  in_data,
    input  logic                 in_last,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy
);

    import max_pool_reducer_pkg::*;

    localparam logic [CNT_WIDTH-1:0] MAX_LEN = CNT_WIDTH'(MAX_POOL);
    localparam logic [CNT_WIDTH-1:0] ONE     = CNT_WIDTH'(1);

    pool_state_t                  state;
    logic [CNT_WIDTH-1:0]         cnt;
    logic [CNT_WIDTH-1:0]         win_len;
    logic signed [OUT_WIDTH-1:0]  acc;

    logic                         accept;
    logic                         close;
    logic [CNT_WIDTH-1:0]         first_len;
    logic [CNT_WIDTH-1:0]         cur_len;
    logic [CNT_WIDTH-1:0]         next_cnt;
    logic signed [OUT_WIDTH-1:0]  samp_ext;
    logic signed [OUT_WIDTH-1:0]  cmp_max;
    logic signed [OUT_WIDTH-1:0]  new_max;
    logic signed [OUT_WIDTH-1:0]  res;

    // A pending result blocks input only while it is not being consumed this cycle,
    // so a new window may close on the same edge the old result leaves.
    assign in_ready = !(out_valid && !out_ready);
    assign accept   = in_valid && in_ready;
    assign busy     = (state == ACCUM);

    assign samp_ext = OUT_WIDTH'(signed'(in_data));

    signed_max_comparator #(
        .IN_WIDTH  (OUT_WIDTH),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_cmp (
        .a       (acc),
        .b       (samp_ext),
        .max_val (cmp_max)
    );

    // Window length for a window starting now: 0 means 1, oversize clamps to MAX_POOL.
    always_comb begin
        first_len = pool_size;
        if (pool_size == '0)
            first_len = ONE;
        else if (pool_size > MAX_LEN)
            first_len = MAX_LEN;
    end

    // The first sample of a window bypasses the compare (acc holds a stale value).
    assign cur_len  = (state == IDLE) ? first_len : win_len;
    assign next_cnt = cnt + ONE;
    assign new_max  = (state == IDLE) ? samp_ext : cmp_max;
    assign close    = accept && (in_last || (next_cnt >= cur_len));

    always_comb begin
        res = new_max;
`ifdef RELU_POOL_EN
        if (new_max[OUT_WIDTH-1])
            res = '0;
`else
`endif
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            cnt       <= '0;
            win_len   <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            if (accept) begin
                acc <= new_max;
                if (state == IDLE)
                    win_len <= first_len;
                if (close) begin
                    cnt       <= '0;
                    state     <= IDLE;
                    out_valid <= 1'b1;
                    out_data  <= res;
                end else begin
                    cnt   <= next_cnt;
                    state <= ACCUM;
                end
            end
        end
    end

endmodule

// File: tb/tb_max_pool_reducer.sv
module tb_max_pool_reducer;

    logic       clk = 1'b0;
    logic       resetn;
    logic [4:0] pool_size;
    logic [7:0] in_data;
    logic       in_last;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       busy;

    int nchk = 0;
    int nerr = 0;

    max_pool_reducer dut (
        .clk       (clk),
        .resetn    (resetn),
        .pool_size (pool_size),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] relu(input logic [7:0] v);
`ifdef RELU_POOL_EN
        return v[7] ? 8'h00 : v;
`else
        return v;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one sample for one edge, then sample outputs 1 time unit after the edge.
    task automatic send(input logic [7:0] d, input logic last, input logic [4:0] ps);
        in_valid  = 1'b1;
        in_data   = d;
        in_last   = last;
        pool_size = ps;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        resetn = 1'b0; pool_size = 5'd4; in_data = '0; in_last = 0; in_valid = 0; out_ready = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst out_valid", out_valid, 0);
        chk("rst out_data", out_data, 0);
        chk("rst busy", busy, 0);
        chk("rst in_ready", in_ready, 1);
        resetn = 1'b1;
        idle();

        // 1: pool 4, 3,-7,12,5 -> 12
        send(8'd3, 0, 5'd4);
        chk("t1 busy", busy, 1);
        chk("t1 no early valid", out_valid, 0);
        send(8'hF9, 0, 5'd4);
        send(8'd12, 0, 5'd4);
        chk("t1 valid before close", out_valid, 0);
        send(8'd5, 0, 5'd4);
        chk("t1 valid", out_valid, 1);
        chk("t1 data", out_data, relu(8'd12));
        chk("t1 busy after close", busy, 0);
        idle();
        chk("t1 consumed", out_valid, 0);

        // 2: pool 2, -128,-128,-1,-100 -> -128, -1
        send(8'h80, 0, 5'd2);
        send(8'h80, 0, 5'd2);
        chk("t2 valid a", out_valid, 1);
        chk("t2 data a", out_data, relu(8'h80));
        send(8'hFF, 0, 5'd2);
        chk("t2 mid", out_valid, 0);
        send(8'h9C, 0, 5'd2);
        chk("t2 valid b", out_valid, 1);
        chk("t2 data b", out_data, relu(8'hFF));
        idle();

        // 3: pool 8, 1,9,4(last) -> 9, then 2(last) -> 2
        send(8'd1, 0, 5'd8);
        send(8'd9, 0, 5'd8);
        send(8'd4, 1, 5'd8);
        chk("t3 valid a", out_valid, 1);
        chk("t3 data a", out_data, 8'd9);
        chk("t3 busy", busy, 0);
        send(8'd2, 1, 5'd8);
        chk("t3 valid b", out_valid, 1);
        chk("t3 data b", out_data, 8'd2);
        idle();

        // 4: back-pressure
        out_ready = 1'b0;
        send(8'd10, 0, 5'd2);
        send(8'd20, 0, 5'd2);
        chk("t4 valid", out_valid, 1);
        chk("t4 data", out_data, 8'd20);
        chk("t4 in_ready low", in_ready, 0);
        // Offer a sample while blocked; it must not be taken.
        in_valid = 1'b1; in_data = 8'd99; pool_size = 5'd1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("t4 hold valid", out_valid, 1);
            chk("t4 hold data", out_data, 8'd20);
        end
        chk("t4 busy while blocked", busy, 0);
        // Release back-pressure on the cycle the next single-sample window closes.
        out_ready = 1'b1; in_data = 8'd33;
        #1;
        chk("t4 in_ready open", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("t4 next valid", out_valid, 1);
        chk("t4 next data", out_data, 8'd33);
        idle();
        chk("t4 drained", out_valid, 0);

        // 5: pass-through and mid-window pool_size change
        send(8'd7, 0, 5'd0);
        chk("t5 ps0 valid", out_valid, 1);
        chk("t5 ps0 data", out_data, 8'd7);
        send(8'hFD, 0, 5'd1);
        chk("t5 ps1 valid", out_valid, 1);
        chk("t5 ps1 data", out_data, relu(8'hFD));
        idle();
        send(8'd1, 0, 5'd3);
        send(8'd2, 0, 5'd2);
        chk("t5 no close at 2", out_valid, 0);
        chk("t5 busy", busy, 1);
        send(8'd3, 0, 5'd2);
        chk("t5 close at 3", out_valid, 1);
        chk("t5 data", out_data, 8'd3);
        idle();

        // 6: reset mid-window
        send(8'd50, 0, 5'd4);
        send(8'd60, 0, 5'd4);
        chk("t6 busy pre", busy, 1);
        #2 resetn = 1'b0;
        #1;
        chk("t6 rst busy", busy, 0);
        chk("t6 rst valid", out_valid, 0);
        @(posedge clk); #1;
        resetn = 1'b1;
        idle();
        send(8'd5, 0, 5'd4);
        send(8'd6, 0, 5'd4);
        send(8'd7, 0, 5'd4);
        chk("t6 no early", out_valid, 0);
        send(8'd8, 0, 5'd4);
        chk("t6 valid", out_valid, 1);
        chk("t6 data", out_data, 8'd8);
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
        $finish;
    end

endmodule
